// File: rtl/uop_pkg.sv
// uop_pkg: register codes, opcode bytes and decode-entry types shared by the micro-op sequencer.
package uop_pkg;
    localparam int CODE_W = 3;
    localparam int TBL_STEPS = 3;
    localparam logic [CODE_W-1:0] NONE = 3'd0, ESP = 3'd1, EBP = 3'd2, EAX = 3'd3, EIP = 3'd4, STK = 3'd5, EDI = 3'd6, EBX = 3'd7;
    localparam logic [7:0] OP_PUSH_EBP = 8'h55, OP_PUSH_EBX = 8'h53, OP_MOV_RM = 8'h89, OP_MOV_EAX = 8'hB8,
                           OP_POP_EBP = 8'h5D, OP_RET = 8'hC3, OP_CALL = 8'hE8, OP_PUSH_IMM = 8'h6A,
                           OP_MOV_LD = 8'h8B, OP_GRP1 = 8'h83, OP_LEAVE = 8'hC9;
    typedef struct packed {
        logic [CODE_W-1:0] load;
        logic [CODE_W-1:0] sel;
    } step_t;
    typedef struct packed {
        step_t [TBL_STEPS-1:0] steps;
        logic [1:0] count;
        logic [3:0] len;
        logic legal;
    } entry_t;
    localparam step_t Z = '0;
    // Unknown opcodes decode to a single all-zero step of length 1.
    localparam entry_t NOP_ENTRY = {18'd0, 2'd1, 4'd1, 1'b0};
    function automatic entry_t mk(input logic [1:0] count, input logic [3:0] len, input step_t s0, input step_t s1, input step_t s2);
        return {s2, s1, s0, count, len, 1'b1};
    endfunction
endpackage

// File: rtl/uop_rom.sv
// uop_rom: combinational lookup from the top opcode half-word to its micro-op list entry.
module uop_rom import uop_pkg::*; (
    input  logic [15:0] op,
    output entry_t      ent
);
    logic [7:0] b0, b1;
    assign b0 = op[15:8];
    assign b1 = op[7:0];
    always_comb begin
        case (b0)
            OP_PUSH_EBP: ent = mk(2'd2, 4'd1, {ESP, EBP}, {ESP, ESP}, Z);
            OP_PUSH_EBX: ent = mk(2'd2, 4'd1, {ESP, EBP}, {ESP, EBX}, Z);
            OP_MOV_RM:   ent = (b1 == 8'hE5) ? mk(2'd1, 4'd2, {EBP, EBP}, Z, Z) :
                               (b1 == 8'hC3) ? mk(2'd1, 4'd2, {EBP, EDI}, Z, Z) : NOP_ENTRY;
            OP_MOV_EAX:  ent = mk(2'd1, 4'd5, {EAX, EAX}, Z, Z);
            OP_POP_EBP:  ent = mk(2'd2, 4'd1, {EBP, EIP}, {EBP, EBP}, Z);
            OP_RET:      ent = mk(2'd2, 4'd1, {EIP, EIP}, {EBP, EBP}, Z);
            OP_CALL:     ent = mk(2'd3, 4'd5, {ESP, EBP}, {ESP, EAX}, {EIP, EBP});
            OP_PUSH_IMM: ent = mk(2'd2, 4'd2, {ESP, EBP}, {ESP, EIP}, Z);
            OP_MOV_LD:   ent = (b1 inside {[8'h40:8'h47]}) ? mk(2'd2, 4'd3, {STK, STK}, {EAX, EDI}, Z) :
                               (b1 inside {[8'h80:8'h87]}) ? mk(2'd2, 4'd6, {STK, STK}, {EAX, EDI}, Z) : NOP_ENTRY;
            OP_GRP1:     ent = (b1 == 8'hE8) ? mk(2'd1, 4'd3, {EAX, EDI}, Z, Z) :
                               (b1 == 8'hC4 || b1 == 8'hEC) ? mk(2'd1, 4'd3, {ESP, EBP}, Z, Z) :
                               (b1 inside {[8'h78:8'h7F]}) ? mk(2'd2, 4'd4, {STK, STK}, {EDI, EDI}, Z) : NOP_ENTRY;
            OP_LEAVE:    ent = mk(2'd3, 4'd1, {ESP, STK}, {STK, STK}, {EBP, ESP});
            default:     ent = NOP_ENTRY;
        endcase
    end
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: captures an opcode word, issues its micro-ops over valid/ready and reports the EIP advance.
// Define UOP_ILLEGAL_TRAP_EN to trap unknown opcodes (sticky illegal) instead of issuing a NOP step.
module uop_sequencer import uop_pkg::*; #(
    parameter int OPE_W     = 32,
    parameter int REG_W     = 4,
    parameter int MAX_STEPS = 3,
    parameter int LEN_W     = 4
) (
    input  logic                         clk2,
    input  logic                         reset,
    input  logic [OPE_W-1:0]             ope,
    input  logic                         ope_valid,
    output logic                         ope_ready,
    output logic                         uop_valid,
    input  logic                         uop_ready,
    output logic [REG_W-1:0]             uop_load,
    output logic [REG_W-1:0]             uop_sel,
    output logic [$clog2(MAX_STEPS)-1:0] uop_step,
    output logic                         uop_last,
    output logic                         eip_adv_valid,
    output logic [LEN_W-1:0]             eip_adv,
    output logic                         illegal
);
    localparam int SW = $clog2(MAX_STEPS);
    localparam int IW = $clog2(TBL_STEPS);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, TRAP = 2'd2;
`ifdef UOP_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    if (MAX_STEPS < TBL_STEPS || REG_W < CODE_W || LEN_W < 3 || OPE_W < 17) begin : g_cfg_check
        $error("uop_sequencer: decode table does not fit the configured parameters");
    end

    logic [1:0]    state;
    logic [SW-1:0] step;
    entry_t        ent, dec;
    logic          issuing, last, fire, done, take, unused_bits;

    uop_rom u_rom (.op(ope[OPE_W-1 -: 16]), .ent(dec));

    assign unused_bits = ^{ope[OPE_W-17:0], ent.legal};
    assign issuing   = state == ISSUE;
    assign last      = issuing && (step + SW'(1) == SW'(ent.count));
    assign fire      = issuing && uop_ready;
    assign done      = fire && last;
    // Opening the capture window on the final accepted step gives back-to-back issue with no bubble.
    assign ope_ready = (state == IDLE) || (last && uop_ready);
    assign take      = ope_valid && ope_ready;
    assign uop_valid = issuing;
    assign uop_load  = issuing ? REG_W'(ent.steps[step[IW-1:0]].load) : '0;
    assign uop_sel   = issuing ? REG_W'(ent.steps[step[IW-1:0]].sel) : '0;
    assign uop_step  = step;
    assign uop_last  = last;

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ent           <= '0;
            step          <= '0;
            eip_adv_valid <= 1'b0;
            eip_adv       <= '0;
            illegal       <= 1'b0;
        end else begin
            eip_adv_valid <= done;
            eip_adv       <= done ? LEN_W'(ent.len) : '0;
            if (take && TRAP_EN && !dec.legal) begin
                state   <= TRAP;
                illegal <= 1'b1;
            end else if (take) begin
                state <= ISSUE;
                ent   <= dec;
                step  <= '0;
            end else if (done) begin
                state <= IDLE;
                step  <= '0;
            end else if (fire) begin
                step <= step + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed latency checks plus a randomized scoreboard against a table-level model.
// With UOP_ILLEGAL_TRAP_EN defined, unknown opcodes are checked for the trap instead of the NOP step.
module tb_uop_sequencer;
    logic        clk2 = 1'b0, reset = 1'b0, ope_valid = 1'b0, uop_ready = 1'b1;
    logic [31:0] ope = '0;
    logic        ope_ready, uop_valid, uop_last, eip_adv_valid, illegal;
    logic [3:0]  uop_load, uop_sel, eip_adv;
    logic [1:0]  uop_step;
    int          total = 0, bad = 0;
    bit          rand_en = 0, mon_en = 0, stalled = 0;
    logic [11:0] held;

    typedef struct {int ld; int sl; int st; bit last;} exp_t;
    exp_t uq[$];
    int   lq[$];
    int   tl[$], ts[$];

    uop_sequencer dut (
        .clk2(clk2), .reset(reset), .ope(ope), .ope_valid(ope_valid), .ope_ready(ope_ready),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_load(uop_load), .uop_sel(uop_sel),
        .uop_step(uop_step), .uop_last(uop_last), .eip_adv_valid(eip_adv_valid), .eip_adv(eip_adv),
        .illegal(illegal)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void st(input int l, input int s);
        tl.push_back(l);
        ts.push_back(s);
    endfunction

    // Reference decode: (load,sel) pairs and byte length straight from the opcode table.
    function automatic int model(input logic [15:0] op);
        logic [7:0] a, b;
        a = op[15:8];
        b = op[7:0];
        tl.delete();
        ts.delete();
        case (a)
            8'h55: begin st(1, 2); st(1, 1); return 1; end
            8'h53: begin st(1, 2); st(1, 7); return 1; end
            8'hB8: begin st(3, 3); return 5; end
            8'h5D: begin st(2, 4); st(2, 2); return 1; end
            8'hC3: begin st(4, 4); st(2, 2); return 1; end
            8'hE8: begin st(1, 2); st(1, 3); st(4, 2); return 5; end
            8'h6A: begin st(1, 2); st(1, 4); return 2; end
            8'hC9: begin st(1, 5); st(5, 5); st(2, 1); return 1; end
            8'h89: begin
                if (b == 8'hE5) begin st(2, 2); return 2; end
                if (b == 8'hC3) begin st(2, 6); return 2; end
            end
            8'h8B: begin
                if (b >= 8'h40 && b <= 8'h47) begin st(5, 5); st(3, 6); return 3; end
                if (b >= 8'h80 && b <= 8'h87) begin st(5, 5); st(3, 6); return 6; end
            end
            8'h83: begin
                if (b == 8'hE8) begin st(3, 6); return 3; end
                if (b == 8'hC4 || b == 8'hEC) begin st(1, 2); return 3; end
                if (b >= 8'h78 && b <= 8'h7F) begin st(5, 5); st(6, 6); return 4; end
            end
            default: ;
        endcase
        st(0, 0);
        return 1;
    endfunction

    function automatic void expect_op(input logic [15:0] op);
        int   len;
        exp_t e;
        len = model(op);
        for (int i = 0; i < tl.size(); i++) begin
            e.ld = tl[i];
            e.sl = ts[i];
            e.st = i;
            e.last = (i == tl.size() - 1);
            uq.push_back(e);
        end
        lq.push_back(len);
    endfunction

    task automatic send(input logic [15:0] op, input int gap);
        int w = 0;
        ope = {op, 16'($urandom)};
        ope_valid = 1'b1;
        @(negedge clk2);
        while (!ope_ready && w < 100) begin
            @(negedge clk2);
            w++;
        end
        if (!ope_ready) begin
            total++;
            bad++;
            $display("FAIL capture_timeout op=%h", op);
        end else expect_op(op);
        @(posedge clk2);
        #1 ope_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk2);
            #1;
        end
    endtask

    initial forever begin
        @(posedge clk2);
        #1;
        if (rand_en) uop_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk2) begin
        if (mon_en) begin
            exp_t e;
            if (stalled) chk("stall_hold", {uop_valid, uop_load, uop_sel, uop_step, uop_last}, held);
            stalled = uop_valid && !uop_ready;
            held = {uop_valid, uop_load, uop_sel, uop_step, uop_last};
            if (uop_valid && uop_ready) begin
                if (uq.size() == 0) chk("unexpected_uop", 1, 0);
                else begin
                    e = uq.pop_front();
                    chk("uop_load", uop_load, e.ld);
                    chk("uop_sel", uop_sel, e.sl);
                    chk("uop_step", uop_step, e.st);
                    chk("uop_last", uop_last, e.last);
                end
            end
            if (eip_adv_valid) begin
                if (lq.size() == 0) chk("unexpected_eip", 1, 0);
                else chk("eip_adv", eip_adv, lq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        logic [7:0] singles [8] = '{8'h55, 8'h53, 8'hB8, 8'h5D, 8'hC3, 8'hE8, 8'h6A, 8'hC9};
        logic [15:0] op;
        repeat (2) @(negedge clk2);
        chk("rst_ope_ready", ope_ready, 1);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_uop_load", uop_load, 0);
        chk("rst_uop_sel", uop_sel, 0);
        chk("rst_uop_step", uop_step, 0);
        chk("rst_uop_last", uop_last, 0);
        chk("rst_eip_valid", eip_adv_valid, 0);
        chk("rst_eip_adv", eip_adv, 0);
        chk("rst_illegal", illegal, 0);
        reset = 1'b1;
        // 0x55 with ready held: two steps then the length pulse.
        @(posedge clk2); #1 ope = 32'h55AA_1234; ope_valid = 1'b1;
        @(posedge clk2); #1 ope_valid = 1'b0;
        @(negedge clk2);
        chk("p55_s0", {uop_valid, uop_load, uop_sel, uop_step, uop_last}, {1'b1, 4'd1, 4'd2, 2'd0, 1'b0});
        @(negedge clk2);
        chk("p55_s1", {uop_valid, uop_load, uop_sel, uop_step, uop_last}, {1'b1, 4'd1, 4'd1, 2'd1, 1'b1});
        @(negedge clk2);
        chk("p55_eip", {eip_adv_valid, eip_adv, uop_valid}, {1'b1, 4'd1, 1'b0});
        // Reset while E8 sits at step 1 discards it.
        @(posedge clk2); #1 ope = 32'hE800_0000; ope_valid = 1'b1;
        @(posedge clk2); #1 ope_valid = 1'b0;
        @(negedge clk2);
        chk("e8_s0_step", uop_step, 0);
        @(negedge clk2);
        chk("e8_s1_step", uop_step, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", {uop_valid, ope_ready, uop_load, uop_sel, uop_step, uop_last}, {1'b0, 1'b1, 11'd0});
        @(negedge clk2) reset = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk2);
            if (eip_adv_valid || uop_valid) seen = 1;
        end
        chk("mid_rst_quiet", seen, 0);
        chk("mid_rst_ready", ope_ready, 1);
        // B8 then C9 with ope_valid held: no bubble between them.
        @(posedge clk2); #1 ope = 32'hB800_0000; ope_valid = 1'b1;
        @(posedge clk2); #1 ope = 32'hC900_0000;
        @(negedge clk2);
        chk("b8_s0", {uop_valid, uop_load, uop_sel, uop_last, ope_ready}, {1'b1, 4'd3, 4'd3, 1'b1, 1'b1});
        @(posedge clk2); #1 ope_valid = 1'b0;
        @(negedge clk2);
        chk("c9_s0", {uop_valid, uop_load, uop_sel, uop_step}, {1'b1, 4'd1, 4'd5, 2'd0});
        chk("b8_eip", {eip_adv_valid, eip_adv}, {1'b1, 4'd5});
        @(negedge clk2);
        chk("c9_s1", {uop_load, uop_sel, uop_step}, {4'd5, 4'd5, 2'd1});
        @(negedge clk2);
        chk("c9_s2", {uop_load, uop_sel, uop_step, uop_last}, {4'd2, 4'd1, 2'd2, 1'b1});
        @(negedge clk2);
        chk("c9_eip", {eip_adv_valid, eip_adv}, {1'b1, 4'd1});
        // Randomized phase under the scoreboard.
        @(posedge clk2); #1;
        mon_en = 1;
        rand_en = 1;
        send(16'hE800, 0);
        send(16'h8B45, 1);
        send(16'h8B85, 0);
`ifndef UOP_ILLEGAL_TRAP_EN
        send(16'h9000, 1);
`endif
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 5);
`ifdef UOP_ILLEGAL_TRAP_EN
            if (k == 5) k = 0;
`endif
            case (k)
                0, 1: op = {singles[$urandom_range(0, 7)], 8'($urandom)};
                2: op = {8'h8B, ($urandom_range(0, 1) != 0 ? 8'h40 : 8'h80) | 8'($urandom_range(0, 7))};
                3: begin
                    int j = $urandom_range(0, 3);
                    op = {8'h83, j == 0 ? 8'hE8 : j == 1 ? 8'hC4 : j == 2 ? 8'hEC : 8'h78 | 8'($urandom_range(0, 7))};
                end
                4: op = {8'h89, $urandom_range(0, 1) != 0 ? 8'hE5 : 8'hC3};
                default: op = 16'($urandom);
            endcase
            send(op, $urandom_range(0, 2));
        end
        for (int i = 0; i < 300 && (uq.size() != 0 || lq.size() != 0); i++) @(negedge clk2);
        chk("drain_uops", uq.size(), 0);
        chk("drain_eip", lq.size(), 0);
        mon_en = 0;
        rand_en = 0;
`ifdef UOP_ILLEGAL_TRAP_EN
        @(negedge clk2) reset = 1'b0;
        @(negedge clk2) reset = 1'b1;
        @(posedge clk2); #1 ope = 32'h9000_0000; ope_valid = 1'b1;
        @(posedge clk2); #1 ope_valid = 1'b0;
        repeat (3) @(negedge clk2);
        chk("trap", {illegal, uop_valid, ope_ready, eip_adv_valid}, {1'b1, 1'b0, 1'b0, 1'b0});
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
